// File: rtl/raw_pattern_pkg.sv
// Shared constants for the RAW8 Bayer test-pattern source: pattern modes,
// colour-bar RGB table, FSM encoding and the Bayer bar lookup.
package raw_pattern_pkg;

  localparam logic [1:0] PAT_FLAT  = 2'd0;
  localparam logic [1:0] PAT_RAMP  = 2'd1;
  localparam logic [1:0] PAT_BARS  = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  // Index 0 is the leftmost bar (white), index 7 the rightmost (black); bits are {R,G,B}.
  localparam logic [7:0][2:0] BAR_RGB = {3'b000, 3'b001, 3'b100, 3'b101,
                                         3'b010, 3'b011, 3'b110, 3'b111};

  // RGGB site select: even row/even col = R, odd row/odd col = B, else G.
  function automatic logic [7:0] bayer_bar(input logic [2:0] bar, input logic x_odd,
                                           input logic y_odd);
    logic [2:0] rgb;
    logic       hit;
    rgb = BAR_RGB[bar];
    if (!y_odd && !x_odd)    hit = rgb[2];
    else if (y_odd && x_odd) hit = rgb[0];
    else                     hit = rgb[1];
    return hit ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/raw_pattern_gen_timing.sv
// Raster counters plus registered sync/den/frame_done decode. Counters sit at
// (0,0) whenever run is low, so a new frame always starts from the origin.
module video_timing_gen #(
  parameter int source_h = 512,
  parameter int source_v = 512,
  parameter int h_blank  = 128,
  parameter int v_blank  = 16,
  parameter int hsync_w  = 32,
  parameter int vsync_w  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic [11:0] h_cnt,
  output logic [11:0] v_cnt,
  output logic        line_end,
  output logic        frame_end,
  output logic        active,
  output logic        den,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_done
);

  localparam logic [11:0] H_LAST     = 12'(source_h + h_blank - 1);
  localparam logic [11:0] V_LAST     = 12'(source_v + v_blank - 1);
  // 13-bit bounds: a sync pulse may end exactly at a 4096 total.
  localparam logic [12:0] H_ACT      = 13'(source_h);
  localparam logic [12:0] H_SYNC_END = 13'(source_h + hsync_w);
  localparam logic [12:0] V_ACT      = 13'(source_v);
  localparam logic [12:0] V_SYNC_END = 13'(source_v + vsync_w);

  logic [12:0] x, y;
  logic        hsync_c, vsync_c;

  assign x         = {1'b0, h_cnt};
  assign y         = {1'b0, v_cnt};
  assign line_end  = run && (h_cnt == H_LAST);
  assign frame_end = line_end && (v_cnt == V_LAST);
  assign active    = run && (x < H_ACT) && (y < V_ACT);
  assign hsync_c   = run && (x >= H_ACT) && (x < H_SYNC_END);
  assign vsync_c   = run && (y >= V_ACT) && (y < V_SYNC_END);

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      h_cnt <= 12'd0;
      v_cnt <= 12'd0;
    end else if (line_end) begin
      h_cnt <= 12'd0;
      v_cnt <= frame_end ? 12'd0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      den        <= 1'b0;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      den        <= active;
      hsync      <= hsync_c;
      vsync      <= vsync_c;
      frame_done <= frame_end;
    end
  end

endmodule

// File: rtl/raw_pattern_gen.sv
// Synthetic RAW8 RGGB video source: run/stop FSM, frame-aligned mode latch,
// pattern datapath and output registers around the raster timing generator.
module raw_pattern_gen
  import raw_pattern_pkg::*;
#(
  parameter int source_h = 512,
  parameter int source_v = 512,
  parameter int h_blank  = 128,
  parameter int v_blank  = 16,
  parameter int hsync_w  = 32,
  parameter int vsync_w  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_mode,
  output logic        out_vsync,
  output logic        out_hsync,
  output logic        out_den,
  output logic [7:0]  out_data,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam logic [11:0] BAR_LAST = 12'(source_h / 8 - 1);

  logic [1:0]  state, state_nxt;
  logic        run;
  logic [11:0] h_cnt, v_cnt;
  logic        line_end, frame_end, active, origin;
  logic [1:0]  mode_q, mode_eff;
  logic [11:0] bar_cnt;
  logic [2:0]  bar_idx;
  logic [7:0]  pix;

  assign run = (state != ST_IDLE);

  video_timing_gen #(
    .source_h(source_h), .source_v(source_v), .h_blank(h_blank),
    .v_blank(v_blank), .hsync_w(hsync_w), .vsync_w(vsync_w)
  ) u_timing (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .line_end  (line_end),
    .frame_end (frame_end),
    .active    (active),
    .den       (out_den),
    .hsync     (out_hsync),
    .vsync     (out_vsync),
    .frame_done(frame_done)
  );

  // STOP only differs from RUN in that it remembers a pending stop; the
  // frame always finishes and enable at the last pixel decides what follows.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (enable) state_nxt = ST_RUN;
      ST_RUN: begin
        if (frame_end)   state_nxt = enable ? ST_RUN : ST_IDLE;
        else if (!enable) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (frame_end)   state_nxt = enable ? ST_RUN : ST_IDLE;
        else if (enable) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset)          frame_cnt <= 16'd0;
    else if (frame_end) frame_cnt <= frame_cnt + 16'd1;
  end

  // Pixel (0,0) already uses the new mode, so bypass the latch there.
  assign origin   = (h_cnt == 12'd0) && (v_cnt == 12'd0);
  assign mode_eff = origin ? pattern_mode : mode_q;

  always_ff @(posedge clk) begin
    if (reset)       mode_q <= PAT_FLAT;
    else if (origin) mode_q <= pattern_mode;
  end

  // Bar index tracks h_cnt with a width counter instead of dividing x.
  always_ff @(posedge clk) begin
    if (reset || !run || line_end) begin
      bar_cnt <= 12'd0;
      bar_idx <= 3'd0;
    end else if (bar_cnt == BAR_LAST) begin
      bar_cnt <= 12'd0;
      bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_cnt <= bar_cnt + 12'd1;
    end
  end

  always_comb begin
    pix = 8'h00;
    case (mode_eff)
      PAT_FLAT:  pix = 8'h80;
      PAT_RAMP:  pix = h_cnt[7:0];
      PAT_BARS:  pix = bayer_bar(bar_idx, h_cnt[0], v_cnt[0]);
      PAT_CHECK: pix = (h_cnt[3] ^ v_cnt[3] ^ frame_cnt[0]) ? 8'hFF : 8'h00;
      default:   pix = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) out_data <= 8'h00;
    else       out_data <= active ? pix : 8'h00;
  end

endmodule

// File: tb/tb_raw_pattern_gen.sv
// Randomised bench for raw_pattern_gen against a frame-index reference model.
module tb_raw_pattern_gen;

  localparam int SH = 16, SV = 4, HB = 8, VB = 2, HW = 4, VW = 1;
  localparam int HT = SH + HB, VT = SV + VB, FT = HT * VT;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [1:0]  pattern_mode;
  logic        out_vsync, out_hsync, out_den, frame_done;
  logic [7:0]  out_data;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  raw_pattern_gen #(
    .source_h(SH), .source_v(SV), .h_blank(HB),
    .v_blank(VB), .hsync_w(HW), .vsync_w(VW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .pattern_mode(pattern_mode),
    .out_vsync(out_vsync), .out_hsync(out_hsync), .out_den(out_den),
    .out_data(out_data), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  int n_chk = 0, n_pass = 0;

  // Model: whether a frame is in flight, linear position t in the frame,
  // completed frame count and the latched mode.
  bit run_m;
  int t, fc, mode_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0d fc=%0d)", tag, obs, exp, t, fc);
  endtask

  function automatic logic [7:0] ref_pix(input int x, input int y, input int md, input int f);
    int rgb_tab [8];
    int rgb, ch;
    rgb_tab = '{7, 6, 3, 2, 5, 4, 1, 0};
    case (md)
      0: return 8'h80;
      1: return 8'(x % 256);
      2: begin
        rgb = rgb_tab[x / (SH / 8)];
        if (y % 2 == 0 && x % 2 == 0)      ch = 2;
        else if (y % 2 == 1 && x % 2 == 1) ch = 0;
        else                               ch = 1;
        return ((rgb >> ch) & 1) != 0 ? 8'hFF : 8'h00;
      end
      default: return ((x / 8 + y / 8 + f) % 2) != 0 ? 8'hFF : 8'h00;
    endcase
  endfunction

  task automatic tick();
    logic [3:0] e_sync;
    logic [7:0] e_data;
    int x, y, md;
    e_sync = 4'b0;
    e_data = 8'h00;
    if (!reset && run_m) begin
      x  = t % HT;
      y  = t / HT;
      md = (t == 0) ? int'(pattern_mode) : mode_m;
      e_sync = {(y >= SV && y < SV + VW), (x >= SH && x < SH + HW),
                (x < SH && y < SV), (t == FT - 1)};
      if (x < SH && y < SV) e_data = ref_pix(x, y, md, fc);
    end
    @(posedge clk);
    if (reset) begin
      run_m = 1'b0; t = 0; fc = 0;
    end else if (!run_m) begin
      if (enable) begin run_m = 1'b1; t = 0; end
    end else begin
      if (t == 0) mode_m = int'(pattern_mode);
      if (t == FT - 1) begin
        fc = (fc + 1) % 65536;
        t = 0;
        run_m = enable;
      end else begin
        t++;
      end
    end
    #1;
    chk("sync", 32'({out_vsync, out_hsync, out_den, frame_done}), 32'(e_sync));
    chk("data", 32'(out_data), 32'(e_data));
    chk("fcnt", 32'(frame_cnt), 32'(fc));
  endtask

  task automatic run_to(input int pos);
    for (int i = 0; i < 2 * FT && !(run_m && t == pos); i++) tick();
    chk("reach_pos", 32'(t), 32'(pos));
  endtask

  initial begin
    int cnt, nfd, fc_before;
    reset = 1'b1; enable = 1'b0; pattern_mode = 2'd0;
    run_m = 1'b0; t = 0; fc = 0; mode_m = 0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    // Start latency: first den two edges after enable is sampled
    pattern_mode = 2'd1;
    enable = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      cnt++;
      if (out_den) break;
    end
    chk("start_lat", 32'(cnt), 32'd2);

    repeat (2 * FT) tick();
    // Mid-frame mode change only applies from next frame's origin
    run_to(60);
    pattern_mode = 2'd2;
    repeat (2 * FT) tick();
    run_to(70);
    pattern_mode = 2'd3;
    repeat (3 * FT) tick();
    run_to(5);
    pattern_mode = 2'd0;
    repeat (FT) tick();
    pattern_mode = 2'd2;

    // Stop handshake at pixel (5,1)
    run_to(HT + 5);
    fc_before = int'(frame_cnt);
    enable = 1'b0;
    nfd = 0;
    for (int i = 0; i < FT + 10; i++) begin
      tick();
      if (frame_done) nfd++;
    end
    chk("stop_fd", 32'(nfd), 32'd1);
    chk("stop_fcnt", 32'(frame_cnt), 32'((fc_before + 1) % 65536));
    chk("stop_idle", 32'({out_vsync, out_hsync, out_den, frame_done, out_data}), 32'd0);

    // Reset mid-frame at (10,2), then clean restart
    enable = 1'b1;
    pattern_mode = 2'd1;
    run_to(2 * HT + 10);
    reset = 1'b1;
    tick();
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    chk("rst_outs", 32'({out_vsync, out_hsync, out_den, frame_done, out_data}), 32'd0);
    reset = 1'b0;
    repeat (FT + 20) tick();

    // Random mode changes and enable toggles
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 49) == 0) pattern_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
